// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Purpose  : Loadable down-counter with a one-cycle terminal-count pulse and
//            optional auto-reload. Counts from a programmed value down to
//            zero; used for timeouts and interval generation.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      system clock, rising-edge active
//   rst          in   1      asynchronous reset, active low
//   load         in   1      capture load_value into count and reload register
//   load_value   in   WIDTH  value captured on load
//   start        in   1      restart from the stored reload value
//   abort        in   1      stop and clear the counter (reload value kept)
//   enable       in   1      count enable; low freezes the count
//   auto_reload  in   1      at terminal count, reload and keep running
//   count        out  WIDTH  current counter value (registered)
//   busy         out  1      high while running or paused (registered)
//   done         out  1      one-cycle pulse at terminal count (registered)
// ============================================================================
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             abort,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  state_t           w_go_state;

  // Entering the countdown (load or start) lands in RUN only when enabled,
  // otherwise it parks in PAUSE until enable rises.
  assign w_go_state = enable ? S_RUN : S_PAUSE;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (abort) begin
      count_d = C_ZERO;
      state_d = S_IDLE;
    end else if (load) begin
      reload_d = load_value;
      count_d  = load_value;
      state_d  = (load_value != C_ZERO) ? w_go_state : S_IDLE;
    end else if (start && (reload_q != C_ZERO)) begin
      count_d = reload_q;
      state_d = w_go_state;
    end else begin
      case (state_q)
        S_RUN: begin
          if (!enable) begin
            state_d = S_PAUSE;
          end else if (count_q > C_ONE) begin
            count_d = count_q - C_ONE;
          end else if (count_q == C_ONE) begin
            done_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = C_ZERO;
              state_d = S_IDLE;
            end
          end else begin
            // A zero count while running cannot be reached normally; park safely.
            state_d = S_IDLE;
          end
        end
        // Resuming from PAUSE costs one edge: decrement begins on the next one.
        S_PAUSE: begin
          if (enable) begin
            state_d = S_RUN;
          end
        end
        S_IDLE: begin
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      count_q  <= C_ZERO;
      reload_q <= C_ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer
// Purpose  : Self-checking bench for countdown_timer. A behavioural model
//            tracks count/busy/done from the timer rules and is compared with
//            the DUT on every falling edge; directed sequences also carry
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         enable = 1'b0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .abort       (abort),
    .enable      (enable),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Behavioural model. "Counting" is true when the timer is busy and enable
  // was already high on the previous edge, so a fresh enable (or resume)
  // costs one edge before the count moves.
  logic [W-1:0] m_count = '0;
  logic [W-1:0] m_reload = '0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_en_prev = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_count   <= 4'd0;
      m_reload  <= 4'd0;
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_en_prev <= 1'b0;
    end else begin
      m_en_prev <= enable;
      m_done    <= 1'b0;
      if (abort) begin
        m_count <= 4'd0;
        m_busy  <= 1'b0;
      end else if (load) begin
        m_reload <= load_value;
        m_count  <= load_value;
        m_busy   <= (load_value != 4'd0);
      end else if (start && (m_reload != 4'd0)) begin
        m_count <= m_reload;
        m_busy  <= 1'b1;
      end else if (m_busy && m_en_prev && enable) begin
        if (m_count == 4'd1) begin
          m_done <= 1'b1;
          if (auto_reload) begin
            m_count <= m_reload;
          end else begin
            m_count <= 4'd0;
            m_busy  <= 1'b0;
          end
        end else begin
          m_count <= m_count - 4'd1;
        end
      end
    end
  end

  // Compare process: outputs are sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    n_cmp = n_cmp + 1;
    if (count !== m_count || busy !== m_busy || done !== m_done) begin
      n_bad = n_bad + 1;
      $display("FAIL model_cmp t=%0t: got count=%0d busy=%0b done=%0b, want count=%0d busy=%0b done=%0b",
               $time, count, busy, done, m_count, m_busy, m_done);
    end
    if (done === 1'b1) n_done = n_done + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance one rising edge; inputs then change 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    cyc(); cyc();
    chk("reset_count", int'(count), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b1;
    cyc();

    // Load 5, enabled: 5,4,3,2,1,0 with done at 0
    enable = 1'b1; load = 1'b1; load_value = 4'd5;
    cyc();
    load = 1'b0;
    chk("load5_count", int'(count), 5);
    chk("load5_busy", int'(busy), 1);
    n_done = 0;
    for (int i = 4; i >= 0; i--) begin
      cyc();
      chk("load5_seq_count", int'(count), i);
      chk("load5_seq_done", int'(done), (i == 0) ? 1 : 0);
      chk("load5_seq_busy", int'(busy), (i != 0) ? 1 : 0);
    end
    cyc(); cyc();
    chk("load5_done_once", n_done, 1);

    // Auto-reload with 3: 2,1,3,2,1,3,... done every third edge
    load = 1'b1; load_value = 4'd3; auto_reload = 1'b1;
    cyc();
    load = 1'b0;
    chk("ar3_first", int'(count), 3);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk("ar3_count", int'(count), 3 - (i % 3));
      chk("ar3_done", int'(done), (i % 3 == 0) ? 1 : 0);
      chk("ar3_busy", int'(busy), 1);
    end
    abort = 1'b1; auto_reload = 1'b0;
    cyc();
    abort = 1'b0;
    chk("ar3_abort_count", int'(count), 0);

    // Load 6, pause two edges at 4, resume costs one more edge
    load = 1'b1; load_value = 4'd6;
    cyc();
    load = 1'b0;
    begin
      int exp_seq [9] = '{5, 4, 4, 4, 4, 3, 2, 1, 0};
      for (int i = 0; i < 9; i++) begin
        enable = (i == 2 || i == 3) ? 1'b0 : 1'b1;
        cyc();
        chk("pause_count", int'(count), exp_seq[i]);
        chk("pause_done", int'(done), (i == 8) ? 1 : 0);
      end
    end

    // Load 10, run to 7, then abort+load+start together: abort wins
    enable = 1'b1; load = 1'b1; load_value = 4'd10;
    cyc();
    load = 1'b0;
    cyc(); cyc(); cyc();
    chk("prio_at7", int'(count), 7);
    load = 1'b1; start = 1'b1; abort = 1'b1; load_value = 4'd9;
    cyc();
    load = 1'b0; start = 1'b0; abort = 1'b0;
    chk("prio_abort_count", int'(count), 0);
    chk("prio_abort_busy", int'(busy), 0);
    chk("prio_abort_done", int'(done), 0);
    // reload register survived the abort: start resumes from 10
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_after_abort", int'(count), 10);
    cyc(); cyc(); cyc();
    chk("rerun_at7", int'(count), 7);
    load = 1'b1; start = 1'b1; load_value = 4'd9;
    cyc();
    load = 1'b0; start = 1'b0;
    chk("prio_load_count", int'(count), 9);
    chk("prio_load_busy", int'(busy), 1);

    // Load with enable low parks in PAUSE; resume takes one edge
    enable = 1'b0; load = 1'b1; load_value = 4'd2;
    cyc();
    load = 1'b0;
    chk("pload_count", int'(count), 2);
    chk("pload_busy", int'(busy), 1);
    cyc();
    chk("pload_hold", int'(count), 2);
    enable = 1'b1;
    cyc();
    chk("pload_resume", int'(count), 2);
    cyc();
    chk("pload_dec", int'(count), 1);
    cyc();
    chk("pload_end_count", int'(count), 0);
    chk("pload_end_done", int'(done), 1);

    // Auto-reload with reload value 1: done every enabled edge
    load = 1'b1; load_value = 4'd1; auto_reload = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ar1_count", int'(count), 1);
      chk("ar1_done", int'(done), 1);
    end
    abort = 1'b1; auto_reload = 1'b0;
    cyc();
    abort = 1'b0;

    // Asynchronous reset mid-count
    load = 1'b1; load_value = 4'd15;
    cyc();
    load = 1'b0;
    repeat (5) cyc();
    chk("areset_pre", int'(count), 10);
    #2 rst = 1'b0;
    #1;
    chk("areset_count", int'(count), 0);
    chk("areset_busy", int'(busy), 0);
    cyc();
    rst = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_ignored_count", int'(count), 0);
    chk("start_ignored_busy", int'(busy), 0);

    // Load 0: idle, no done
    n_done = 0;
    load = 1'b1; load_value = 4'd0;
    cyc();
    load = 1'b0;
    chk("load0_count", int'(count), 0);
    chk("load0_busy", int'(busy), 0);
    cyc(); cyc();
    chk("load0_no_done", n_done, 0);

    // Maximum load 15: done after exactly 15 edges
    load = 1'b1; load_value = 4'd15;
    cyc();
    load = 1'b0;
    chk("max_first", int'(count), 15);
    for (int i = 1; i <= 15; i++) begin
      cyc();
      chk("max_count", int'(count), 15 - i);
      chk("max_done", int'(done), (i == 15) ? 1 : 0);
    end
    cyc();
    chk("max_done_cleared", int'(done), 0);
    chk("max_idle_count", int'(count), 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
